// File: rtl/uparc_mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// The response watchdog is built only when UPARC_ARB_TIMEOUT_EN is defined.
package uparc_mem_arbiter_pkg;

  localparam int unsigned UparcAddrWidth = 32;
  localparam int unsigned UparcDataWidth = 32;
  localparam int unsigned UparcBenWidth  = UparcDataWidth / 8;
  localparam int unsigned UparcArbTimeout = 255;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } arb_state_e;

  // D wins unless I is also requesting and D had the previous grant.
  function automatic logic arb_pick_d(input logic req_i, input logic req_d, input logic last_d);
    return req_d & (~req_i | ~last_d);
  endfunction

endpackage

// File: rtl/uparc_mem_arbiter_req_slot.sv
// One request slot: captures a command pulse and its fields, holds a pending flag
// until the response clears it. Pulses while pending are dropped.
module uparc_mem_arbiter_req_slot
  import uparc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = UparcAddrWidth,
  parameter int unsigned DATA_WIDTH = UparcDataWidth,
  parameter int unsigned BEN_WIDTH  = UparcBenWidth
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cmd_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  rnw_i,
  input  logic [BEN_WIDTH-1:0]  ben_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rnw_o,
  output logic [BEN_WIDTH-1:0]  ben_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rnw_q, rnw_d;
  logic [BEN_WIDTH-1:0]  ben_q, ben_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;

  // The owner may re-request in the same cycle its response clears the slot.
  assign accept = cmd_i & (~pend_q | clr_i);

  always_comb begin
    pend_d = accept | (pend_q & ~clr_i);
    addr_d = addr_q;
    rnw_d  = rnw_q;
    ben_d  = ben_q;
    data_d = data_q;
    if (accept) begin
      addr_d = addr_i;
      rnw_d  = rnw_i;
      ben_d  = ben_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_q <= 1'b0;
      addr_q <= '0;
      rnw_q  <= 1'b0;
      ben_q  <= '0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
      rnw_q  <= rnw_d;
      ben_q  <= ben_d;
      data_q <= data_d;
    end
  end

  // Next-state view so a same-cycle pulse can be granted immediately.
  assign req_o  = pend_d;
  assign addr_o = addr_d;
  assign rnw_o  = rnw_d;
  assign ben_o  = ben_d;
  assign data_o = data_d;

endmodule

// File: rtl/uparc_mem_arbiter.sv
// Two-to-one I/D port arbiter onto a single memory port, D-priority with alternation.
// Optional response watchdog: define UPARC_ARB_TIMEOUT_EN.
module uparc_mem_arbiter
  import uparc_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = UparcAddrWidth,
  parameter int unsigned DATA_WIDTH = UparcDataWidth,
  parameter int unsigned BEN_WIDTH  = UparcBenWidth,
  parameter int unsigned TIMEOUT    = UparcArbTimeout
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_IAddr,
  input  logic                  i_IRdC,
  output logic [DATA_WIDTH-1:0] o_IData,
  output logic                  o_IRdy,
  output logic                  o_IErr,
  input  logic [ADDR_WIDTH-1:0] i_DAddr,
  input  logic                  i_DCmd,
  input  logic                  i_DRnW,
  input  logic [BEN_WIDTH-1:0]  i_DBen,
  input  logic [DATA_WIDTH-1:0] i_DData,
  output logic [DATA_WIDTH-1:0] o_DData,
  output logic                  o_DRdy,
  output logic                  o_DErr,
  output logic [ADDR_WIDTH-1:0] o_MAddr,
  output logic                  o_MCmd,
  output logic                  o_MRnW,
  output logic [BEN_WIDTH-1:0]  o_MBen,
  output logic [DATA_WIDTH-1:0] o_MData,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic                  i_MRdy,
  input  logic                  i_MErr
);

  arb_state_e state_q, state_d;
  logic       last_d_q, last_d_d;
  logic                  mcmd_q, mcmd_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  mrnw_q, mrnw_d;
  logic [BEN_WIDTH-1:0]  mben_q, mben_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;

  logic                  req_i, req_d;
  logic [ADDR_WIDTH-1:0] s_i_addr, s_d_addr;
  logic                  s_i_rnw, s_d_rnw;
  logic [BEN_WIDTH-1:0]  s_i_ben, s_d_ben;
  logic [DATA_WIDTH-1:0] s_i_data, s_d_data;

  logic busy_i, busy_d, mem_resp, tmo, resp, done_i, done_d, grant, win_d;

  assign busy_i   = (state_q == StBusyI);
  assign busy_d   = (state_q == StBusyD);
  assign mem_resp = i_MRdy | i_MErr;
  assign resp     = mem_resp | tmo;
  assign done_i   = busy_i & resp;
  assign done_d   = busy_d & resp;
  assign grant    = ((state_q == StIdle) | done_i | done_d) & (req_i | req_d);
  assign win_d    = arb_pick_d(req_i, req_d, last_d_q);

  uparc_mem_arbiter_req_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BEN_WIDTH  (BEN_WIDTH)
  ) u_slot_i (
    .clk    (clk),
    .nrst   (nrst),
    .cmd_i  (i_IRdC),
    .clr_i  (done_i),
    .addr_i (i_IAddr),
    .rnw_i  (1'b1),
    .ben_i  ({BEN_WIDTH{1'b1}}),
    .data_i ({DATA_WIDTH{1'b0}}),
    .req_o  (req_i),
    .addr_o (s_i_addr),
    .rnw_o  (s_i_rnw),
    .ben_o  (s_i_ben),
    .data_o (s_i_data)
  );

  uparc_mem_arbiter_req_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BEN_WIDTH  (BEN_WIDTH)
  ) u_slot_d (
    .clk    (clk),
    .nrst   (nrst),
    .cmd_i  (i_DCmd),
    .clr_i  (done_d),
    .addr_i (i_DAddr),
    .rnw_i  (i_DRnW),
    .ben_i  (i_DBen),
    .data_i (i_DData),
    .req_o  (req_d),
    .addr_o (s_d_addr),
    .rnw_o  (s_d_rnw),
    .ben_o  (s_d_ben),
    .data_o (s_d_data)
  );

`ifdef UPARC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant) begin
      cnt_d = '0;
    end else if (busy_i | busy_d) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo = (busy_i | busy_d) & (cnt_q == CntW'(TIMEOUT)) & ~mem_resp;
`else
  // Without the watchdog TIMEOUT has no effect.
  assign tmo = 1'b0 & (TIMEOUT == 0);
`endif

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    mcmd_d   = 1'b0;
    maddr_d  = maddr_q;
    mrnw_d   = mrnw_q;
    mben_d   = mben_q;
    mdata_d  = mdata_q;
    if (done_i | done_d) begin
      state_d = StIdle;
    end
    if (grant) begin
      state_d  = win_d ? StBusyD : StBusyI;
      last_d_d = win_d;
      mcmd_d   = 1'b1;
      maddr_d  = win_d ? s_d_addr : s_i_addr;
      mrnw_d   = win_d ? s_d_rnw : s_i_rnw;
      mben_d   = win_d ? s_d_ben : s_i_ben;
      mdata_d  = win_d ? s_d_data : s_i_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      last_d_q <= 1'b0;
      mcmd_q   <= 1'b0;
      maddr_q  <= '0;
      mrnw_q   <= 1'b0;
      mben_q   <= '0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      mcmd_q   <= mcmd_d;
      maddr_q  <= maddr_d;
      mrnw_q   <= mrnw_d;
      mben_q   <= mben_d;
      mdata_q  <= mdata_d;
    end
  end

  assign o_MCmd  = mcmd_q;
  assign o_MAddr = maddr_q;
  assign o_MRnW  = mrnw_q;
  assign o_MBen  = mben_q;
  assign o_MData = mdata_q;

  // Both rdy and err together reports as an error only.
  assign o_IRdy  = busy_i & i_MRdy & ~i_MErr;
  assign o_IErr  = busy_i & (i_MErr | tmo);
  assign o_IData = (busy_i & mem_resp) ? i_MData : '0;
  assign o_DRdy  = busy_d & i_MRdy & ~i_MErr;
  assign o_DErr  = busy_d & (i_MErr | tmo);
  assign o_DData = (busy_d & mem_resp) ? i_MData : '0;

endmodule

// File: tb/tb_uparc_mem_arbiter.sv
// Directed self-checking bench for uparc_mem_arbiter.
// The watchdog scenario runs only when UPARC_ARB_TIMEOUT_EN is defined.
module tb_uparc_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] i_IAddr;
  logic        i_IRdC;
  logic [31:0] o_IData;
  logic        o_IRdy;
  logic        o_IErr;
  logic [31:0] i_DAddr;
  logic        i_DCmd;
  logic        i_DRnW;
  logic [3:0]  i_DBen;
  logic [31:0] i_DData;
  logic [31:0] o_DData;
  logic        o_DRdy;
  logic        o_DErr;
  logic [31:0] o_MAddr;
  logic        o_MCmd;
  logic        o_MRnW;
  logic [3:0]  o_MBen;
  logic [31:0] o_MData;
  logic [31:0] i_MData;
  logic        i_MRdy;
  logic        i_MErr;

  int total = 0;
  int fails = 0;
  int dcnt  = 0;
  int icnt  = 0;

  always #5 clk = ~clk;

  uparc_mem_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BEN_WIDTH  (4),
    .TIMEOUT    (16)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .i_IAddr (i_IAddr),
    .i_IRdC  (i_IRdC),
    .o_IData (o_IData),
    .o_IRdy  (o_IRdy),
    .o_IErr  (o_IErr),
    .i_DAddr (i_DAddr),
    .i_DCmd  (i_DCmd),
    .i_DRnW  (i_DRnW),
    .i_DBen  (i_DBen),
    .i_DData (i_DData),
    .o_DData (o_DData),
    .o_DRdy  (o_DRdy),
    .o_DErr  (o_DErr),
    .o_MAddr (o_MAddr),
    .o_MCmd  (o_MCmd),
    .o_MRnW  (o_MRnW),
    .o_MBen  (o_MBen),
    .o_MData (o_MData),
    .i_MData (i_MData),
    .i_MRdy  (i_MRdy),
    .i_MErr  (i_MErr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0;
    i_IAddr = '0; i_IRdC = 1'b0;
    i_DAddr = '0; i_DCmd = 1'b0; i_DRnW = 1'b0; i_DBen = '0; i_DData = '0;
    i_MData = '0; i_MRdy = 1'b0; i_MErr = 1'b0;

    // Reset state
    tick(); tick(); #2;
    chk("rst_mcmd", o_MCmd, 1'b0);
    chk("rst_maddr", o_MAddr, 32'h0);
    chk("rst_irdy", o_IRdy, 1'b0);
    chk("rst_drdy", o_DRdy, 1'b0);
    nrst = 1'b1;

    // Single fetch, plus a dropped duplicate pulse while in flight
    tick(); i_IAddr = 32'h100; i_IRdC = 1'b1; #2;
    chk("f_pre_cmd", o_MCmd, 1'b0);
    tick(); i_IRdC = 1'b0; #2;
    chk("f_cmd", o_MCmd, 1'b1);
    chk("f_addr", o_MAddr, 32'h100);
    chk("f_rnw", o_MRnW, 1'b1);
    chk("f_ben", o_MBen, 4'hF);
    tick(); i_IAddr = 32'h999; i_IRdC = 1'b1; #2;
    chk("f_cmd_once", o_MCmd, 1'b0);
    chk("f_addr_hold", o_MAddr, 32'h100);
    tick(); i_IRdC = 1'b0;
    tick(); i_MRdy = 1'b1; i_MData = 32'hDEADBEEF; #2;
    chk("f_irdy", o_IRdy, 1'b1);
    chk("f_idata", o_IData, 32'hDEADBEEF);
    chk("f_ierr", o_IErr, 1'b0);
    chk("f_drdy", o_DRdy, 1'b0);
    chk("f_ddata", o_DData, 32'h0);
    tick(); i_MRdy = 1'b0; #2;
    chk("f_irdy_off", o_IRdy, 1'b0);
    chk("f_dup_ignored", o_MCmd, 1'b0);

    // Simultaneous requests, last grant I: D first, then I with no bubble
    tick();
    i_IAddr = 32'h200; i_IRdC = 1'b1;
    i_DAddr = 32'h300; i_DRnW = 1'b0; i_DBen = 4'h3; i_DData = 32'h1234; i_DCmd = 1'b1;
    tick(); i_IRdC = 1'b0; i_DCmd = 1'b0; #2;
    chk("s_cmd_d", o_MCmd, 1'b1);
    chk("s_addr_d", o_MAddr, 32'h300);
    chk("s_rnw_d", o_MRnW, 1'b0);
    chk("s_ben_d", o_MBen, 4'h3);
    chk("s_data_d", o_MData, 32'h1234);
    tick(); i_MRdy = 1'b1; i_MData = 32'h0; #2;
    chk("s_drdy", o_DRdy, 1'b1);
    chk("s_irdy_quiet", o_IRdy, 1'b0);
    tick(); i_MRdy = 1'b0; #2;
    chk("s_cmd_i", o_MCmd, 1'b1);
    chk("s_addr_i", o_MAddr, 32'h200);
    chk("s_rnw_i", o_MRnW, 1'b1);
    tick(); i_MRdy = 1'b1; i_MData = 32'hCAFE; #2;
    chk("s_irdy", o_IRdy, 1'b1);
    chk("s_idata", o_IData, 32'hCAFE);
    tick(); i_MRdy = 1'b0;

    // Alternation: owner re-requests in its response cycle
    i_IAddr = 32'h600; i_IRdC = 1'b1;
    i_DAddr = 32'h500; i_DRnW = 1'b1; i_DCmd = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick(); i_IRdC = 1'b0; i_DCmd = 1'b0; i_MRdy = 1'b0; #2;
      chk("alt_cmd", o_MCmd, 1'b1);
      chk("alt_addr", o_MAddr, (t % 2 == 0) ? 32'h500 : 32'h600);
      tick(); i_MRdy = 1'b1; i_MData = t;
      if (t < 6) begin
        if (t % 2 == 0) i_DCmd = 1'b1;
        else i_IRdC = 1'b1;
      end
      #2;
      dcnt += int'(o_DRdy);
      icnt += int'(o_IRdy);
    end
    tick(); i_MRdy = 1'b0; i_IRdC = 1'b0; i_DCmd = 1'b0; #2;
    chk("alt_drain", o_MCmd, 1'b0);
    chk("alt_dcnt", dcnt, 4);
    chk("alt_icnt", icnt, 4);

    // Error routing: rdy and err together
    tick(); i_DAddr = 32'h400; i_DRnW = 1'b1; i_DCmd = 1'b1;
    tick(); i_DCmd = 1'b0; #2;
    chk("e_addr", o_MAddr, 32'h400);
    tick(); i_MRdy = 1'b1; i_MErr = 1'b1; i_MData = 32'h77; #2;
    chk("e_derr", o_DErr, 1'b1);
    chk("e_drdy", o_DRdy, 1'b0);
    chk("e_irdy", o_IRdy, 1'b0);
    chk("e_ierr", o_IErr, 1'b0);
    chk("e_idata", o_IData, 32'h0);

    // Stray response in idle is not forwarded
    tick(); #2;
    chk("idle_derr", o_DErr, 1'b0);
    chk("idle_drdy", o_DRdy, 1'b0);
    chk("idle_ierr", o_IErr, 1'b0);
    chk("idle_cmd", o_MCmd, 1'b0);
    tick(); i_MRdy = 1'b0; i_MErr = 1'b0;

    // Reset in BUSY_I abandons the fetch
    tick(); i_IAddr = 32'h700; i_IRdC = 1'b1;
    tick(); i_IRdC = 1'b0; #2;
    chk("r_addr", o_MAddr, 32'h700);
    tick(); #2;
    nrst = 1'b0; i_MRdy = 1'b1; i_MData = 32'h55; #1;
    chk("r_irdy", o_IRdy, 1'b0);
    chk("r_idata", o_IData, 32'h0);
    chk("r_maddr", o_MAddr, 32'h0);
    chk("r_mben", o_MBen, 4'h0);
    chk("r_mrnw", o_MRnW, 1'b0);
    tick(); nrst = 1'b1; #2;
    chk("r_post_irdy", o_IRdy, 1'b0);
    chk("r_post_cmd", o_MCmd, 1'b0);
    tick(); i_MRdy = 1'b0; #2;
    chk("r_post_cmd2", o_MCmd, 1'b0);

`ifdef UPARC_ARB_TIMEOUT_EN
    // Watchdog: no response, error 16 cycles after the grant, then D goes
    tick(); i_IAddr = 32'h800; i_IRdC = 1'b1;
    tick(); i_IRdC = 1'b0; i_DAddr = 32'h900; i_DRnW = 1'b1; i_DCmd = 1'b1; #2;
    chk("t_cmd", o_MCmd, 1'b1);
    chk("t_addr", o_MAddr, 32'h800);
    tick(); i_DCmd = 1'b0;
    repeat (14) tick();
    #2;
    chk("t_early", o_IErr, 1'b0);
    tick(); #2;
    chk("t_ierr", o_IErr, 1'b1);
    chk("t_irdy", o_IRdy, 1'b0);
    tick(); #2;
    chk("t_ierr_off", o_IErr, 1'b0);
    chk("t_next_cmd", o_MCmd, 1'b1);
    chk("t_next_addr", o_MAddr, 32'h900);
    tick(); i_MRdy = 1'b1; #2;
    chk("t_drdy", o_DRdy, 1'b1);
    tick(); i_MRdy = 1'b0;
`endif

    tick();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
